cmos_window_mix: RTL and testbench



---
 rtl/cmos_window_mix.sv | 121 ++++++++++++
 tb/tb_cmos_window_mix.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cmos_window_mix.sv
// cmos_window_mix: crops a programmable window from a pixel stream, fans it out to NUM_PATHS processing paths and returns one of them
// Ports: pixel_clk/rst (sync, active-high); pdata_i/de_i/vs_i input stream;
//   h_start/h_len/v_start/v_len/mode requested window and path, applied at frame start;
//   crop_data/crop_de/crop_vs cropped stream to all paths;
//   path_data/path_de/path_vs path returns (path k at [k*DW +: DW]);
//   pdata_o/de_o/vs_o selected output; line_err sticky output line-length mismatch.
module cmos_window_mix #(
  parameter int DW = 16,
  parameter int XW = 12,
  parameter int NUM_PATHS = 4,
  parameter int MODE_W = 2,
  parameter int DEF_H_START = 80,
  parameter int DEF_H_LEN = 320,
  parameter int DEF_V_START = 0,
  parameter int DEF_V_LEN = 480
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic [DW-1:0]           pdata_i,
  input  logic                    de_i,
  input  logic                    vs_i,
  input  logic [XW-1:0]           h_start,
  input  logic [XW-1:0]           h_len,
  input  logic [XW-1:0]           v_start,
  input  logic [XW-1:0]           v_len,
  input  logic [MODE_W-1:0]       mode,
  output logic [DW-1:0]           crop_data,
  output logic                    crop_de,
  output logic                    crop_vs,
  input  logic [NUM_PATHS*DW-1:0] path_data,
  input  logic [NUM_PATHS-1:0]    path_de,
  input  logic [NUM_PATHS-1:0]    path_vs,
  output logic [DW-1:0]           pdata_o,
  output logic                    de_o,
  output logic                    vs_o,
  output logic                    line_err
);
  localparam logic [XW-1:0] sat_max = '1;
  logic vs_d, de_d, armed, vs_o_d, de_o_d, frame_start, in_win, vs_rise, sel_de, sel_vs;
  logic [XW-1:0] x_cnt, y_cnt, hs, hl, vs0, vl, chk_len, lcnt;
  logic [XW:0] dx, dy;
  logic [MODE_W-1:0] in_mode, out_mode, sel;
  logic [NUM_PATHS-1:0] pvs_d;
  logic [DW-1:0] sel_data;
  assign frame_start = vs_i & ~vs_d;
  // one extra bit so a column left of the window shows up as a borrow and start+len can never wrap
  assign dx = {1'b0, x_cnt} - {1'b0, hs};
  assign dy = {1'b0, y_cnt} - {1'b0, vs0};
  assign in_win = ~dx[XW] & (dx < {1'b0, hl}) & ~dy[XW] & (dy < {1'b0, vl});
  // the pending path takes over on the very cycle its vsync rises
  always_comb begin
    vs_rise = 1'b0;
    sel_data = '0;
    sel_de = 1'b0;
    sel_vs = 1'b0;
    for (int k = 0; k < NUM_PATHS; k++)
      if (in_mode == MODE_W'(k)) vs_rise = path_vs[k] & ~pvs_d[k];
    sel = vs_rise ? in_mode : out_mode;
    for (int k = 0; k < NUM_PATHS; k++)
      if (sel == MODE_W'(k)) begin
        sel_data = path_data[k*DW +: DW];
        sel_de = path_de[k];
        sel_vs = path_vs[k];
      end
  end
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      armed <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
      hs <= XW'(DEF_H_START);
      hl <= XW'(DEF_H_LEN);
      vs0 <= XW'(DEF_V_START);
      vl <= XW'(DEF_V_LEN);
      in_mode <= '0;
      out_mode <= '0;
      pvs_d <= '0;
      crop_data <= '0;
      crop_de <= 1'b0;
      crop_vs <= 1'b0;
      pdata_o <= '0;
      de_o <= 1'b0;
      vs_o <= 1'b0;
      vs_o_d <= 1'b0;
      de_o_d <= 1'b0;
      chk_len <= XW'(DEF_H_LEN);
      lcnt <= '0;
      line_err <= 1'b0;
    end else begin
      vs_d <= vs_i;
      de_d <= de_i;
      x_cnt <= de_i ? ((x_cnt == sat_max) ? x_cnt : x_cnt + 1'b1) : '0;
      if (frame_start) begin
        hs <= h_start;
        hl <= h_len;
        vs0 <= v_start;
        vl <= v_len;
        in_mode <= (int'(mode) < NUM_PATHS) ? mode : '0;
        y_cnt <= '0;
        armed <= 1'b1;
      end else if (de_d & ~de_i & (y_cnt != sat_max)) begin
        y_cnt <= y_cnt + 1'b1;
      end
      crop_de <= armed & de_i & in_win;
      crop_data <= pdata_i;
      crop_vs <= vs_i;
      pvs_d <= path_vs;
      out_mode <= sel;
      pdata_o <= sel_data;
      de_o <= sel_de;
      vs_o <= sel_vs;
      vs_o_d <= vs_o;
      de_o_d <= de_o;
      if (vs_o & ~vs_o_d) chk_len <= hl;
      lcnt <= de_o ? ((lcnt == sat_max) ? lcnt : lcnt + 1'b1) : '0;
      if (de_o_d & ~de_o & (lcnt != '0) & (lcnt != chk_len)) line_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmos_window_mix.sv
// tb_cmos_window_mix: randomized frames against a frame-level reference model of cmos_window_mix
module tb_cmos_window_mix;
  localparam int DW = 16, XW = 12, NP = 4, MW = 3;
  logic clk = 0, rst = 1;
  logic [DW-1:0] pdata_i = '0, crop_data, pdata_o;
  logic de_i = 0, vs_i = 0, crop_de, crop_vs, de_o, vs_o, line_err;
  logic [XW-1:0] h_start = '0, h_len = '0, v_start = '0, v_len = '0;
  logic [MW-1:0] mode = '0;
  logic [NP*DW-1:0] path_data = '0;
  logic [NP-1:0] path_de = '0, path_vs = '0;
  cmos_window_mix #(.DW(DW), .XW(XW), .NUM_PATHS(NP), .MODE_W(MW)) dut (
    .pixel_clk(clk), .rst(rst), .pdata_i(pdata_i), .de_i(de_i), .vs_i(vs_i),
    .h_start(h_start), .h_len(h_len), .v_start(v_start), .v_len(v_len), .mode(mode),
    .crop_data(crop_data), .crop_de(crop_de), .crop_vs(crop_vs),
    .path_data(path_data), .path_de(path_de), .path_vs(path_vs),
    .pdata_o(pdata_o), .de_o(de_o), .vs_o(vs_o), .line_err(line_err));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cycn = 0;
  bit go = 0;
  int r_rst = 1, r_hs = 80, r_hl = 320, r_vs = 0, r_vl = 480, r_mode = 0;
  bit trunc = 0, prev_any = 0;
  int dly [NP] = '{0, 3, 5, 2};
  bit hd [8], hv [8];
  bit [DW-1:0] hdat [8];
  int x_cur = 0, x_prev = 0, t80 = 0, tc = -1, tde = -1, first_x = -1, ccount = 0, ocount = 0;
  int m_armed = 0, m_hs = 80, m_hl = 320, m_v0 = 0, m_vl = 480, m_in = 0, m_out = 0;
  int m_chk = 320, m_err = 0, m_cnt = 0;
  bit p_vs = 0, p_de_o = 0, p_vs_o = 0;
  bit [NP-1:0] p_pvs = '0;
  logic [DW-1:0] e_cd = '0, n_cd = '0, e_pd = '0, n_pd = '0;
  logic e_cde = 0, n_cde = 0, e_cvs = 0, n_cvs = 0, e_de = 0, n_de = 0;
  logic e_vs = 0, n_vs = 0, e_err = 0, n_err = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cycn, act, exp);
    end
  endtask
  // one pixel clock: paths are the cropped stream replayed with per-path delay, model predicts the next edge
  task automatic cyc(input bit de, input bit vs, input int x, input int y);
    bit [DW-1:0] pd;
    bit [NP-1:0] pde, pvs;
    bit [NP*DW-1:0] pdat;
    bit any;
    int i;
    @(posedge clk);
    #1;
    cycn++;
    {e_cd, e_cde, e_cvs, e_pd, e_de, e_vs, e_err} = {n_cd, n_cde, n_cvs, n_pd, n_de, n_vs, n_err};
    hd[cycn & 7] = crop_de;
    hv[cycn & 7] = crop_vs;
    hdat[cycn & 7] = crop_data;
    for (int k = 0; k < NP; k++) begin
      i = (cycn - dly[k]) & 7;
      pde[k] = hd[i];
      pvs[k] = hv[i];
      pdat[k*DW +: DW] = hdat[i] ^ DW'(k * 'h1357);
    end
    any = |pde;
    if (trunc && any && !prev_any) begin
      pde = '0;
      trunc = 0;
    end
    prev_any = any;
    pd = DW'($urandom);
    rst = r_rst[0];
    pdata_i = pd;
    de_i = de;
    vs_i = vs;
    h_start = XW'(r_hs);
    h_len = XW'(r_hl);
    v_start = XW'(r_vs);
    v_len = XW'(r_vl);
    mode = MW'(r_mode);
    path_de = pde;
    path_vs = pvs;
    path_data = pdat;
    x_prev = x_cur;
    x_cur = x;
    if (de && x == 80 && y == 0) t80 = cycn;
    if (r_rst != 0) begin
      {n_cd, n_cde, n_cvs, n_pd, n_de, n_vs, n_err} = '0;
      m_armed = 0; m_hs = 80; m_hl = 320; m_v0 = 0; m_vl = 480; m_in = 0; m_out = 0;
      m_chk = 320; m_err = 0; m_cnt = 0;
      p_vs = 0; p_de_o = 0; p_vs_o = 0; p_pvs = '0;
    end else begin
      if (p_de_o && !e_de && m_cnt != 0 && m_cnt != m_chk) m_err = 1;
      m_cnt = e_de ? ((m_cnt < 4095) ? m_cnt + 1 : m_cnt) : 0;
      if (e_vs && !p_vs_o) m_chk = m_hl;
      p_de_o = e_de;
      p_vs_o = e_vs;
      n_cde = (m_armed != 0) && de && x >= m_hs && (x - m_hs) < m_hl && y >= m_v0 && (y - m_v0) < m_vl;
      n_cd = pd;
      n_cvs = vs;
      if (pvs[m_in] && !p_pvs[m_in]) m_out = m_in;
      n_pd = pdat[m_out*DW +: DW];
      n_de = pde[m_out];
      n_vs = pvs[m_out];
      p_pvs = pvs;
      if (vs && !p_vs) begin
        m_hs = r_hs; m_hl = r_hl; m_v0 = r_vs; m_vl = r_vl;
        m_in = (r_mode < NP) ? r_mode : 0;
        m_armed = 1;
      end
      p_vs = vs;
      n_err = m_err[0];
    end
  endtask
  task automatic frame(input int w, input int h, input int rst_line, input int chg_hs, input int chg_mode);
    tc = -1; tde = -1; first_x = -1; ccount = 0; ocount = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y == 1 && x == 0 && chg_hs >= 0) r_hs = chg_hs;
        if (y == 1 && x == 0 && chg_mode >= 0) r_mode = chg_mode;
        r_rst = (y == rst_line && x >= 100 && x < 103) ? 1 : 0;
        cyc(1, 0, x, y);
      end
      r_rst = 0;
      for (int i = 0; i < 3 + int'($urandom_range(0, 5)); i++) cyc(0, 0, 0, 0);
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
  endtask
  always @(negedge clk) if (go) begin
    check("crop_de", crop_de, e_cde);
    check("crop_data", crop_data, e_cd);
    check("crop_vs", crop_vs, e_cvs);
    check("de_o", de_o, e_de);
    check("pdata_o", pdata_o, e_pd);
    check("vs_o", vs_o, e_vs);
    check("line_err", line_err, e_err);
    if (crop_de) begin
      ccount++;
      if (tc < 0) begin tc = cycn; first_x = x_prev; end
    end
    if (de_o) begin
      ocount++;
      if (tde < 0) tde = cycn;
    end
  end
  initial begin
    r_rst = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      if (i == 1) go = 1;
    end
    check("rst crop_de", crop_de, 0);
    check("rst de_o", de_o, 0);
    check("rst vs_o", vs_o, 0);
    check("rst pdata_o", pdata_o, 0);
    check("rst line_err", line_err, 0);
    r_rst = 0;
    frame(640, 4, -1, -1, -1);
    check("f1 crop count", ccount, 1280);
    check("f1 out count", ocount, 1280);
    check("f1 first x", first_x, 80);
    check("f1 crop latency", tc - t80, 1);
    check("f1 out latency", tde - t80, 2);
    frame(640, 4, -1, 10, -1);
    check("f2 first x", first_x, 80);
    check("f2 crop count", ccount, 1280);
    frame(640, 4, -1, -1, 2);
    check("f3 first x", first_x, 10);
    check("f3 out count", ocount, 1280);
    frame(640, 4, -1, -1, 7);
    check("f4 out count", ocount, 1280);
    frame(640, 4, -1, -1, -1);
    check("f5 out count", ocount, 1280);
    check("f5 line_err", line_err, 0);
    trunc = 1;
    frame(640, 4, -1, -1, -1);
    check("trunc out count", ocount, 1279);
    check("trunc line_err", line_err, 1);
    frame(640, 4, -1, -1, -1);
    check("sticky line_err", line_err, 1);
    r_hs = 80;
    frame(640, 4, 1, -1, -1);
    check("rst mid crop count", ccount, 340);
    check("rst mid line_err", line_err, 0);
    r_hl = 0;
    frame(640, 3, -1, -1, -1);
    check("hlen0 crop count", ccount, 0);
    r_hl = 320; r_vs = 1; r_vl = 2;
    frame(640, 5, -1, -1, -1);
    check("vwin crop count", ccount, 640);
    for (int f = 0; f < 10; f++) begin
      r_hs = $urandom_range(0, 120);
      case ($urandom_range(0, 3))
        0: r_hl = 0;
        1: r_hl = 4095;
        default: r_hl = $urandom_range(1, 150);
      endcase
      r_vs = $urandom_range(0, 3);
      r_vl = ($urandom_range(0, 3) == 0) ? 4095 : $urandom_range(0, 5);
      r_mode = $urandom_range(0, 7);
      frame($urandom_range(40, 160), $urandom_range(2, 6), -1, -1, int'($urandom_range(0, 7)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
